// File: rtl/serial_word_queue.sv
// Serial-in word queue: assembles a bit stream into DATA_WIDTH-bit words,
// buffers them in a DEPTH-entry circular FIFO and pops them in parallel on request.
module serial_word_queue #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned LSB_FIRST  = 0
) (
   input  logic                           clock_1MHz,
   input  logic                           rst,
   input  logic                           data_in,
   input  logic                           write_in,
   input  logic                           dequeue_in,
   output logic                           status_out,
   output logic [DATA_WIDTH-1:0]          data_out,
   output logic                           data_valid_out,
   output logic [$clog2(DEPTH+1)-1:0]     len_out,
   output logic                           full_out,
   output logic                           empty_out,
   output logic                           err_out
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LEN_W = $clog2(DEPTH + 1);

   logic [CNT_W-1:0]      cnt_q,        cnt_d;
   logic [DATA_WIDTH-1:0] shift_q,      shift_d;
   logic [DATA_WIDTH-1:0] hold_q,       hold_d;
   logic                  hold_valid_q, hold_valid_d;
   logic [PTR_W-1:0]      wr_ptr_q,     wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q,     rd_ptr_d;
   logic [LEN_W-1:0]      len_q,        len_d;
   logic                  full_q,       full_d;
   logic                  empty_q,      empty_d;
   logic [DATA_WIDTH-1:0] data_q,       data_d;
   logic                  valid_q,      valid_d;
   logic                  err_q,        err_d;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  bit_acc;
   logic                  deq;
   logic                  xfer;
   logic [DATA_WIDTH-1:0] shifted;

   // Next-state logic for deserialiser, hold stage, FIFO pointers and output registers
   always_comb begin
      cnt_d        = cnt_q;
      shift_d      = shift_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      data_d       = data_q;
      valid_d      = 1'b0;
      err_d        = err_q;

      bit_acc = write_in & ~hold_valid_q;
      deq     = dequeue_in & (len_q != '0);
      // A full FIFO still takes the held word when the head leaves at the same edge
      xfer    = hold_valid_q & ((len_q < LEN_W'(DEPTH)) | deq);

      if (LSB_FIRST != 0) begin
         shifted = {data_in, shift_q[DATA_WIDTH-1:1]};
      end else begin
         shifted = {shift_q[DATA_WIDTH-2:0], data_in};
      end

      if (bit_acc) begin
         if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            hold_d       = shifted;
            hold_valid_d = 1'b1;
            cnt_d        = '0;
            shift_d      = '0;
         end else begin
            shift_d = shifted;
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end

      if (write_in & hold_valid_q) begin
         err_d = 1'b1;
      end

      if (xfer) begin
         hold_valid_d = 1'b0;
         wr_ptr_d     = wr_ptr_q + PTR_W'(1);
      end

      if (deq) begin
         data_d   = mem[rd_ptr_q];
         valid_d  = 1'b1;
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      len_d   = len_q + LEN_W'(xfer) - LEN_W'(deq);
      full_d  = (len_d == LEN_W'(DEPTH));
      empty_d = (len_d == '0);
   end

   // State registers
   always_ff @(posedge clock_1MHz or negedge rst) begin
      if (!rst) begin
         cnt_q        <= '0;
         shift_q      <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         len_q        <= '0;
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
         data_q       <= '0;
         valid_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         shift_q      <= shift_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         len_q        <= len_d;
         full_q       <= full_d;
         empty_q      <= empty_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         err_q        <= err_d;
      end
   end

   // Storage array; contents are don't-care until written, so no reset
   always_ff @(posedge clock_1MHz) begin
      if (xfer) begin
         mem[wr_ptr_q] <= hold_q;
      end
   end

   assign status_out     = ~hold_valid_q;
   assign data_out       = data_q;
   assign data_valid_out = valid_q;
   assign len_out        = len_q;
   assign full_out       = full_q;
   assign empty_out      = empty_q;
   assign err_out        = err_q;

endmodule

// File: tb/tb_serial_word_queue.sv
// Bench for serial_word_queue: directed scenarios plus a randomized run against
// a queue-based reference model; MSB-first and LSB-first instances share stimulus.
module tb_serial_word_queue;

   localparam int unsigned W  = 8;
   localparam int unsigned D  = 8;
   localparam int unsigned LW = $clog2(D + 1);

   logic clk = 1'b0;
   logic rst_n;
   logic data_in, write_in, dequeue_in;

   logic          status_m, valid_m, full_m, empty_m, err_m;
   logic [W-1:0]  dout_m;
   logic [LW-1:0] len_m;
   logic          status_l, valid_l, full_l, empty_l, err_l;
   logic [W-1:0]  dout_l;
   logic [LW-1:0] len_l;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state
   int unsigned q_m[$];
   int unsigned q_l[$];
   int unsigned acc_m, acc_l, nbits;
   int unsigned hold_m, hold_l;
   bit          hold_v;
   int unsigned mdout_m, mdout_l;
   bit          mvalid, merr;

   always #5 clk = ~clk;

   serial_word_queue #(.DATA_WIDTH(W), .DEPTH(D), .LSB_FIRST(0)) dut (
      .clock_1MHz(clk), .rst(rst_n), .data_in(data_in), .write_in(write_in),
      .dequeue_in(dequeue_in), .status_out(status_m), .data_out(dout_m),
      .data_valid_out(valid_m), .len_out(len_m), .full_out(full_m),
      .empty_out(empty_m), .err_out(err_m)
   );

   serial_word_queue #(.DATA_WIDTH(W), .DEPTH(D), .LSB_FIRST(1)) dut_lsb (
      .clock_1MHz(clk), .rst(rst_n), .data_in(data_in), .write_in(write_in),
      .dequeue_in(dequeue_in), .status_out(status_l), .data_out(dout_l),
      .data_valid_out(valid_l), .len_out(len_l), .full_out(full_l),
      .empty_out(empty_l), .err_out(err_l)
   );

   task automatic model_reset();
      q_m.delete(); q_l.delete();
      acc_m = 0; acc_l = 0; nbits = 0;
      hold_m = 0; hold_l = 0; hold_v = 0;
      mdout_m = 0; mdout_l = 0; mvalid = 0; merr = 0;
   endtask

   // One clock edge of the reference behaviour, from pre-edge state
   task automatic model_step(input logic wr, input logic d, input logic dq);
      bit ready = !hold_v;
      bit pop   = dq && (q_m.size() > 0);
      bit move  = hold_v && ((q_m.size() < D) || pop);
      mvalid = pop;
      if (pop) begin
         mdout_m = q_m.pop_front();
         mdout_l = q_l.pop_front();
      end
      if (move) begin
         q_m.push_back(hold_m);
         q_l.push_back(hold_l);
         hold_v = 0;
      end
      if (wr && !ready) merr = 1;
      if (wr && ready) begin
         acc_m = acc_m * 2 + int'(d);
         acc_l = acc_l + (int'(d) << nbits);
         nbits++;
         if (nbits == W) begin
            hold_m = acc_m % (1 << W);
            hold_l = acc_l % (1 << W);
            hold_v = 1;
            acc_m = 0; acc_l = 0; nbits = 0;
         end
      end
   endtask

   task automatic tick(input logic wr, input logic d, input logic dq);
      write_in = wr; data_in = d; dequeue_in = dq;
      @(posedge clk);
      model_step(wr, d, dq);
      #1;
      write_in = 1'b0; data_in = 1'b0; dequeue_in = 1'b0;
   endtask

   // Eight MSB-first bits of w, then one idle cycle for the hold-to-FIFO move
   task automatic send_word(input logic [W-1:0] w);
      for (int i = W - 1; i >= 0; i--) tick(1'b1, w[i], 1'b0);
      tick(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; write_in = 1'b0; data_in = 1'b0; dequeue_in = 1'b0;
      model_reset();
      #12;
      n_total++;
      if ({status_m, valid_m, dout_m, len_m, full_m, empty_m, err_m} !== {1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0})
         $display("FAIL reset_state: got st=%b v=%b d=%h len=%0d f=%b e=%b err=%b", status_m, valid_m, dout_m, len_m, full_m, empty_m, err_m);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_bit_order();
      logic [W-1:0] pat;
      pat = 8'hA5;
      for (int i = W - 1; i >= 0; i--) tick(1'b1, pat[i], 1'b0);
      n_total++;
      if (status_m !== 1'b0) $display("FAIL status_low_after_word: got %b want 0", status_m);
      else n_pass++;
      tick(1'b0, 1'b0, 1'b0);
      n_total++;
      if ({status_m, len_m, empty_m} !== {1'b1, 4'd1, 1'b0})
         $display("FAIL first_transfer: got st=%b len=%0d e=%b want st=1 len=1 e=0", status_m, len_m, empty_m);
      else n_pass++;
      tick(1'b0, 1'b0, 1'b1);
      n_total++;
      if ({valid_m, dout_m, dout_l, len_m} !== {1'b1, 8'hA5, 8'hA5, 4'd0})
         $display("FAIL pop_a5: got v=%b msb=%h lsb=%h len=%0d want v=1 a5 a5 len=0", valid_m, dout_m, dout_l, len_m);
      else n_pass++;
      tick(1'b0, 1'b0, 1'b0);
      n_total++;
      if ({valid_m, dout_m} !== {1'b0, 8'hA5})
         $display("FAIL pulse_one_cycle: got v=%b d=%h want v=0 d=a5", valid_m, dout_m);
      else n_pass++;
      send_word(8'h80);
      tick(1'b0, 1'b0, 1'b1);
      n_total++;
      if ({dout_m, dout_l} !== {8'h80, 8'h01})
         $display("FAIL bit_order_80: got msb=%h lsb=%h want 80 01", dout_m, dout_l);
      else n_pass++;
   endtask

   task automatic test_full_wrap();
      logic [W-1:0] exp_w;
      for (int k = 0; k < D; k++) send_word(W'(k));
      n_total++;
      if ({full_m, len_m, empty_m} !== {1'b1, 4'd8, 1'b0})
         $display("FAIL fill: got f=%b len=%0d e=%b want f=1 len=8 e=0", full_m, len_m, empty_m);
      else n_pass++;
      send_word(8'hFF);
      n_total++;
      if ({status_m, len_m, err_m} !== {1'b0, 4'd8, 1'b0})
         $display("FAIL stall_when_full: got st=%b len=%0d err=%b want st=0 len=8 err=0", status_m, len_m, err_m);
      else n_pass++;
      tick(1'b1, 1'b1, 1'b0);
      n_total++;
      if ({err_m, status_m} !== {1'b1, 1'b0})
         $display("FAIL drop_sets_err: got err=%b st=%b want err=1 st=0", err_m, status_m);
      else n_pass++;
      tick(1'b0, 1'b0, 1'b1);
      n_total++;
      if ({valid_m, dout_m, full_m, len_m, status_m} !== {1'b1, 8'h00, 1'b1, 4'd8, 1'b1})
         $display("FAIL pop_and_fill_full: got v=%b d=%h f=%b len=%0d st=%b want 1 00 1 8 1", valid_m, dout_m, full_m, len_m, status_m);
      else n_pass++;
      for (int k = 1; k <= D; k++) begin
         exp_w = (k == D) ? 8'hFF : W'(k);
         tick(1'b0, 1'b0, 1'b1);
         n_total++;
         if ({valid_m, dout_m} !== {1'b1, exp_w})
            $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", k, valid_m, dout_m, exp_w);
         else n_pass++;
      end
      n_total++;
      if ({empty_m, len_m, full_m} !== {1'b1, 4'd0, 1'b0})
         $display("FAIL drained_empty: got e=%b len=%0d f=%b", empty_m, len_m, full_m);
      else n_pass++;
   endtask

   task automatic test_empty_and_burst();
      logic [W-1:0] words [3];
      tick(1'b0, 1'b0, 1'b1);
      n_total++;
      if ({valid_m, dout_m, err_m, len_m} !== {1'b0, 8'hFF, 1'b1, 4'd0})
         $display("FAIL empty_dequeue: got v=%b d=%h err=%b len=%0d want 0 ff 1 0", valid_m, dout_m, err_m, len_m);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         words[i] = W'($urandom);
         send_word(words[i]);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0, 1'b1);
         n_total++;
         if ({valid_m, dout_m} !== {1'b1, words[i]})
            $display("FAIL burst_pop_%0d: got v=%b d=%h want v=1 d=%h", i, valid_m, dout_m, words[i]);
         else n_pass++;
      end
      tick(1'b0, 1'b0, 1'b1);
      n_total++;
      if ({valid_m, empty_m, dout_m} !== {1'b0, 1'b1, words[2]})
         $display("FAIL burst_end: got v=%b e=%b d=%h want v=0 e=1 d=%h", valid_m, empty_m, dout_m, words[2]);
      else n_pass++;
   endtask

   task automatic test_reset_midword();
      logic [W-1:0] w;
      send_word(8'h5A);
      send_word(8'hC3);
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_total++;
      if ({len_m, empty_m, err_m, status_m, valid_m} !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0})
         $display("FAIL async_reset: got len=%0d e=%b err=%b st=%b v=%b want 0 1 0 1 0", len_m, empty_m, err_m, status_m, valid_m);
      else n_pass++;
      #2;
      rst_n = 1'b1;
      w = 8'h3C;
      send_word(w);
      tick(1'b0, 1'b0, 1'b1);
      n_total++;
      if ({valid_m, dout_m, dout_l, len_m} !== {1'b1, 8'h3C, 8'h3C, 4'd0})
         $display("FAIL fresh_word: got v=%b msb=%h lsb=%h len=%0d want 1 3c 3c 0", valid_m, dout_m, dout_l, len_m);
      else n_pass++;
   endtask

   task automatic test_random();
      logic wr, d, dq;
      int   bad;
      bad = 0;
      for (int c = 0; c < 1000; c++) begin
         wr = ($urandom_range(0, 99) < 75);
         d  = 1'($urandom);
         dq = ($urandom_range(0, 99) < ((c < 500) ? 8 : 55));
         tick(wr, d, dq);
         n_total++;
         if ({status_m, valid_m, dout_m, len_m, full_m, empty_m, err_m, dout_l} !==
             {!hold_v, mvalid, W'(mdout_m), LW'(q_m.size()), (q_m.size() == D), (q_m.size() == 0), merr, W'(mdout_l)}) begin
            if (bad < 10)
               $display("FAIL random_cycle_%0d: got st=%b v=%b d=%h len=%0d f=%b e=%b err=%b l=%h want st=%b v=%b d=%h len=%0d err=%b l=%h",
                        c, status_m, valid_m, dout_m, len_m, full_m, empty_m, err_m, dout_l,
                        !hold_v, mvalid, W'(mdout_m), q_m.size(), merr, W'(mdout_l));
            bad++;
         end else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_bit_order();
      test_full_wrap();
      test_empty_and_burst();
      test_reset_midword();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/serial_word_queue.md
Name: serial_word_queue

Overview:
- Parametrised successor to the team's 1-bit serial-in queue top.
- Deserialises a bit stream into DATA_WIDTH-bit words and pushes each completed word into a DEPTH-entry circular FIFO.
- Returns the words in parallel on dequeue requests, with a one-cycle valid strobe.
- Adds configurable bit order, occupancy/full/empty reporting and a sticky drop-error flag; sits between the serial front end and the consumer logic on the same clock.

Parameters:
- DATA_WIDTH, 8, bits per assembled word (>=2).
- DEPTH, 8, FIFO entries; power of two, >=2.
- LSB_FIRST, 0, 0: first received bit lands in word MSB; 1: first received bit lands in word LSB.

Ports:
- clock_1MHz  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  1  serial data bit, sampled when write_in=1.
- write_in  input  1  bit strobe; one bit accepted per cycle when write_in=1 and status_out=1.
- dequeue_in  input  1  pop request for the head word.
- status_out  output  1  1 = ready to accept serial bits.
- data_out  output  DATA_WIDTH  last popped word.
- data_valid_out  output  1  one-cycle pulse: data_out updated this cycle.
- len_out  output  $clog2(DEPTH+1)  words currently stored in the FIFO.
- full_out  output  1  len_out==DEPTH.
- empty_out  output  1  len_out==0.
- err_out  output  1  sticky: a write_in bit was dropped.

Behaviour:
- Reset (rst=0, async):
  - bit counter=0, shift register=0, hold_valid=0.
  - FIFO pointers=0, len_out=0, empty_out=1, full_out=0.
  - data_out=0, data_valid_out=0, err_out=0, status_out=1.
  - Reset mid-word discards partial bits; reset mid-stall discards the held word.
- Deserialiser:
  - status_out = !hold_valid (combinational from the register).
  - Accepted bit (write_in & status_out): shifted in per LSB_FIRST; bit counter increments.
  - On the DATA_WIDTH-th accepted bit, the assembled word (including that bit) is copied to the hold register at the same edge.
  - At that edge: hold_valid<=1, bit counter<=0.
- Hold-to-FIFO transfer:
  - Occurs at any edge where hold_valid=1 and (len<DEPTH, or len==DEPTH with an accepted dequeue at that same edge).
  - Word written at the write pointer; pointer wraps modulo DEPTH; hold_valid<=0.
  - With space available, status_out is low for exactly one cycle per word.
  - With the FIFO full, status_out stays low until space frees.
- Dropped bits:
  - write_in=1 while status_out=0: bit ignored, counter unchanged, err_out<=1.
  - err_out is cleared only by reset.
- Dequeue:
  - Accepted when dequeue_in=1 and len_out>0 (state at the edge).
  - Head word is registered into data_out at that edge; data_valid_out=1 for that following cycle only; read pointer wraps modulo DEPTH.
  - data_out holds its value until the next accepted dequeue.
  - dequeue_in on an empty FIFO is ignored: no pulse, data_out unchanged, no error.
  - dequeue_in held high pops one word per cycle while non-empty.
- Simultaneous transfer and dequeue:
  - When non-empty, both occur; len unchanged.
  - When empty, only the transfer occurs; no same-cycle bypass.
  - When full, both occur; len stays DEPTH.
- len_out, full_out, empty_out are registered and consistent with each other every cycle.
- No combinational path from inputs to any output.

Test Plan:
- DATA_WIDTH=8, LSB_FIRST=0: write bits 1,0,1,0,0,1,0,1 on consecutive cycles -> status_out low 1 cycle after 8th bit, then len_out=1, empty_out=0. Pulse dequeue_in -> next cycle data_out=8'hA5, data_valid_out=1 for 1 cycle, len_out=0.
- LSB_FIRST=1, same bit sequence -> dequeued data_out=8'hA5 reversed = 8'hA5 (palindrome). Repeat with bits 1,0,0,0,0,0,0,0 -> data_out=8'h01 (MSB-first gives 8'h80).
- Write 8 words 0..7 (DEPTH=8) -> full_out=1, len_out=8. Send 9th word 8'hFF -> status_out stays 0. Extra write_in sets err_out=1. One dequeue returns 8'h00, and at the same edge 8'hFF enters; full_out stays 1, status_out returns to 1. Drain returns 1..7 then FF in order; pointer wrap verified.
- Dequeue with empty FIFO -> data_valid_out stays 0, data_out unchanged, err_out unchanged. Hold dequeue_in high over 3 stored words -> 3 consecutive valid pulses, then empty_out=1.
- Assert rst low after 5 of 8 bits and while 2 words are stored -> immediately len_out=0, empty_out=1, err_out=0, status_out=1. A fresh 8-bit word after release is assembled from bit 0, with no residue from the partial word.
- 1000 random write_in/dequeue_in cycles against a scoreboard queue -> every popped word matches, len_out matches the model, err_out set only on writes while status_out=0.
